// File: rtl/yapay_zeka_kuyruk.sv
// ============================================================================
// Module      : yapay_zeka_kuyruk
// Description : Dual-push, single-pop first-word-fall-through FIFO. It feeds
//               the yapay zeka unit in the X-instruction execute stage.
//               Each cycle a producer can push zero, one or two words and the
//               consumer can pop one word. The head word is always visible.
//               A push is all-or-nothing. A pop on an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : VERI_W   - data word width in bits
//               DERINLIK - number of entries (power of two, >= 4)
// Ports       : clk_i         - clock, rising edge
//               rst_ni        - synchronous active-low reset
//               temizle_i     - synchronous flush
//               yaz1_en_i     - push yaz1_deger_i
//               yaz1_deger_i  - first push word
//               yaz2_en_i     - also push yaz2_deger_i (only with yaz1_en_i)
//               yaz2_deger_i  - second push word
//               yaz_hazir_o   - at least two free entries
//               oku_en_i      - pop the head word
//               oku_deger_o   - head word (valid when oku_gecerli_o)
//               oku_gecerli_o - FIFO non-empty
//               doluluk_o     - occupancy 0..DERINLIK
//               dolu_o        - FIFO full
//               tasma_o       - sticky overflow flag
//               alt_tasma_o   - sticky underflow flag
// Build macro : YZ_KUYRUK_HATA_BAYRAK_EN - builds the sticky error flags.
//               Without it, tasma_o and alt_tasma_o are tied to 0.
// ============================================================================
`default_nettype none

module yapay_zeka_kuyruk #(
  parameter int VERI_W   = 32,
  parameter int DERINLIK = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        temizle_i,
  input  logic                        yaz1_en_i,
  input  logic [VERI_W-1:0]           yaz1_deger_i,
  input  logic                        yaz2_en_i,
  input  logic [VERI_W-1:0]           yaz2_deger_i,
  output logic                        yaz_hazir_o,
  input  logic                        oku_en_i,
  output logic [VERI_W-1:0]           oku_deger_o,
  output logic                        oku_gecerli_o,
  output logic [$clog2(DERINLIK):0]   doluluk_o,
  output logic                        dolu_o,
  output logic                        tasma_o,
  output logic                        alt_tasma_o
);

  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW:0] DERINLIK_V = (AW+1)'(DERINLIK);

  logic [VERI_W-1:0] mem [DERINLIK];
  logic [AW-1:0]     yp;
  logic [AW-1:0]     op;
  logic [AW:0]       sayi;

  logic [1:0]        n_req;
  logic [1:0]        n_acc;
  logic              pop;
  logic [AW:0]       free_cnt;
  logic              push_ok;
  logic [AW-1:0]     yp_plus1;

  // yaz2_en_i on its own is not a request.
  assign n_req    = yaz1_en_i ? (yaz2_en_i ? 2'd2 : 2'd1) : 2'd0;
  assign pop      = oku_en_i & (sayi != '0);
  // A same-cycle pop frees its slot for the push in that cycle.
  assign free_cnt = DERINLIK_V - sayi + {{AW{1'b0}}, pop};
  assign push_ok  = ({{(AW-1){1'b0}}, n_req} <= free_cnt);
  assign n_acc    = push_ok ? n_req : 2'd0;
  assign yp_plus1 = yp + AW'(1);

  // Storage has no reset. A reset or flush only clears the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !temizle_i) begin
      if (n_acc != 2'd0) mem[yp]       <= yaz1_deger_i;
      if (n_acc == 2'd2) mem[yp_plus1] <= yaz2_deger_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || temizle_i) begin
      yp   <= '0;
      op   <= '0;
      sayi <= '0;
    end else begin
      yp   <= yp + AW'(n_acc);
      op   <= op + AW'(pop);
      sayi <= sayi + (AW+1)'(n_acc) - (AW+1)'(pop);
    end
  end

`ifdef YZ_KUYRUK_HATA_BAYRAK_EN
  logic tasma_q;
  logic alt_tasma_q;
  logic overflow;
  logic underflow;

  assign overflow  = (n_req != 2'd0) & ~push_ok;
  assign underflow = oku_en_i & (sayi == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || temizle_i) begin
      tasma_q     <= 1'b0;
      alt_tasma_q <= 1'b0;
    end else begin
      if (overflow)  tasma_q     <= 1'b1;
      if (underflow) alt_tasma_q <= 1'b1;
    end
  end

  assign tasma_o     = tasma_q;
  assign alt_tasma_o = alt_tasma_q;
`else
  assign tasma_o     = 1'b0;
  assign alt_tasma_o = 1'b0;
`endif

  assign oku_deger_o   = mem[op];
  assign oku_gecerli_o = (sayi != '0);
  assign doluluk_o     = sayi;
  assign dolu_o        = (sayi == DERINLIK_V);
  assign yaz_hazir_o   = ((DERINLIK_V - sayi) >= (AW+1)'(2));

endmodule

`default_nettype wire

// File: tb/tb_yapay_zeka_kuyruk.sv
// ============================================================================
// Module      : tb_yapay_zeka_kuyruk
// Description : Self-checking bench for yapay_zeka_kuyruk. A queue-based
//               reference model is compared with the DUT on every falling
//               edge. Directed scenarios add literal expectations.
//               Macro YZ_KUYRUK_HATA_BAYRAK_EN selects the expected flag
//               behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yapay_zeka_kuyruk;

  localparam int W = 32;
  localparam int D = 16;
`ifdef YZ_KUYRUK_HATA_BAYRAK_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          temizle_i = 1'b0;
  logic          yaz1_en_i = 1'b0;
  logic [W-1:0]  yaz1_deger_i = '0;
  logic          yaz2_en_i = 1'b0;
  logic [W-1:0]  yaz2_deger_i = '0;
  logic          yaz_hazir_o;
  logic          oku_en_i = 1'b0;
  logic [W-1:0]  oku_deger_o;
  logic          oku_gecerli_o;
  logic [4:0]    doluluk_o;
  logic          dolu_o;
  logic          tasma_o;
  logic          alt_tasma_o;

  int total = 0;
  int bad   = 0;

  yapay_zeka_kuyruk #(.VERI_W(W), .DERINLIK(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .temizle_i(temizle_i),
    .yaz1_en_i(yaz1_en_i), .yaz1_deger_i(yaz1_deger_i),
    .yaz2_en_i(yaz2_en_i), .yaz2_deger_i(yaz2_deger_i),
    .yaz_hazir_o(yaz_hazir_o), .oku_en_i(oku_en_i),
    .oku_deger_o(oku_deger_o), .oku_gecerli_o(oku_gecerli_o),
    .doluluk_o(doluluk_o), .dolu_o(dolu_o),
    .tasma_o(tasma_o), .alt_tasma_o(alt_tasma_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] q[$];
  bit m_tasma = 0, m_alt = 0, model_ok = 0;

  always @(posedge clk) begin
    int n, p, fr;
    if (!rst_ni || temizle_i) begin
      q.delete(); m_tasma = 0; m_alt = 0;
      if (!rst_ni) model_ok = 1;
    end else begin
      n  = yaz1_en_i ? (yaz2_en_i ? 2 : 1) : 0;
      p  = (oku_en_i && q.size() > 0) ? 1 : 0;
      if (oku_en_i && q.size() == 0) m_alt = 1;
      fr = D - q.size() + p;
      if (p == 1) void'(q.pop_front());
      if (n <= fr) begin
        if (n >= 1) q.push_back(yaz1_deger_i);
        if (n == 2) q.push_back(yaz2_deger_i);
      end else begin
        m_tasma = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_gecerli", 64'(oku_gecerli_o), 64'(q.size() != 0));
      chk("m_doluluk", 64'(doluluk_o), 64'(q.size()));
      chk("m_dolu", 64'(dolu_o), 64'(q.size() == D));
      chk("m_hazir", 64'(yaz_hazir_o), 64'((D - q.size()) >= 2));
      chk("m_tasma", 64'(tasma_o), 64'(FLAGS_ON & m_tasma));
      chk("m_alt", 64'(alt_tasma_o), 64'(FLAGS_ON & m_alt));
      if (q.size() != 0) chk("m_head", 64'(oku_deger_o), 64'(q[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit y1, input logic [W-1:0] d1, input bit y2,
                     input logic [W-1:0] d2, input bit rd, input bit fl = 1'b0);
    yaz1_en_i = y1; yaz1_deger_i = d1; yaz2_en_i = y2; yaz2_deger_i = d2;
    oku_en_i = rd; temizle_i = fl;
    @(posedge clk); #1;
    yaz1_en_i = 0; yaz2_en_i = 0; oku_en_i = 0; temizle_i = 0;
  endtask

  initial begin
    // reset
    rst_ni = 0; cyc(0, 0, 0, 0, 0); rst_ni = 1;
    chk("rst_doluluk", 64'(doluluk_o), 64'd0);
    chk("rst_gecerli", 64'(oku_gecerli_o), 64'd0);
    chk("rst_dolu", 64'(dolu_o), 64'd0);
    chk("rst_hazir", 64'(yaz_hazir_o), 64'd1);
    chk("rst_tasma", 64'(tasma_o), 64'd0);
    chk("rst_alt", 64'(alt_tasma_o), 64'd0);

    // dual push A,B then pop
    cyc(1, 32'h11, 1, 32'h22, 0);
    chk("ab_doluluk", 64'(doluluk_o), 64'd2);
    chk("ab_head", 64'(oku_deger_o), 64'h11);
    cyc(0, 0, 0, 0, 1);
    chk("ab_pop_head", 64'(oku_deger_o), 64'h22);
    chk("ab_pop_doluluk", 64'(doluluk_o), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("ab_empty", 64'(oku_gecerli_o), 64'd0);

    // fill, overflow, drain
    for (int i = 0; i < 8; i++) cyc(1, 32'(2*i), 1, 32'(2*i+1), 0);
    chk("full_dolu", 64'(dolu_o), 64'd1);
    chk("full_hazir", 64'(yaz_hazir_o), 64'd0);
    cyc(1, 32'hFF, 0, 0, 0);
    chk("ovf_doluluk", 64'(doluluk_o), 64'd16);
    chk("ovf_tasma", 64'(tasma_o), 64'(FLAGS_ON));
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", 64'(oku_deger_o), 64'(i));
      cyc(0, 0, 0, 0, 1);
    end
    chk("drain_empty", 64'(oku_gecerli_o), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("flush_tasma", 64'(tasma_o), 64'd0);

    // occupancy 15 boundary
    for (int i = 0; i < 7; i++) cyc(1, 32'h100 + 32'(i), 1, 32'h200 + 32'(i), 0);
    cyc(1, 32'h300, 0, 0, 0);
    chk("o15", 64'(doluluk_o), 64'd15);
    cyc(1, 32'h400, 1, 32'h401, 1);
    chk("o15_pushpop", 64'(doluluk_o), 64'd16);
    chk("o15_pushpop_tasma", 64'(tasma_o), 64'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h500, 1, 32'h501, 0);
    chk("o15_drop", 64'(doluluk_o), 64'd15);
    chk("o15_drop_tasma", 64'(tasma_o), 64'(FLAGS_ON));
    cyc(0, 0, 0, 0, 0, 1);

    // underflow
    cyc(0, 0, 0, 0, 1);
    chk("udf_alt", 64'(alt_tasma_o), 64'(FLAGS_ON));
    chk("udf_doluluk", 64'(doluluk_o), 64'd0);
    cyc(1, 32'h33, 0, 0, 1);
    chk("udf_push_doluluk", 64'(doluluk_o), 64'd1);
    chk("udf_push_head", 64'(oku_deger_o), 64'h33);
    chk("udf_push_alt", 64'(alt_tasma_o), 64'(FLAGS_ON));
    cyc(0, 0, 0, 0, 0, 1);

    // yaz2 alone is ignored
    cyc(0, 0, 1, 32'h77, 0);
    chk("y2only_doluluk", 64'(doluluk_o), 64'd0);
    chk("y2only_tasma", 64'(tasma_o), 64'd0);

    // 40 cycles of dual push / single pop, which wraps the pointers
    for (int i = 0; i < 40; i++) cyc(1, $urandom, 1, $urandom, 1);
    cyc(1, 32'hAA, 1, 32'hBB, 1, 1);
    chk("flushpush_doluluk", 64'(doluluk_o), 64'd0);
    chk("flushpush_tasma", 64'(tasma_o), 64'd0);
    chk("flushpush_alt", 64'(alt_tasma_o), 64'd0);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst_ni = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 9) < 5, $urandom_range(0, 149) == 0);
    end
    rst_ni = 1;
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/yapay_zeka_kuyruk.md
# yapay_zeka_kuyruk

Parametrised dual-push, single-pop FIFO for the yapay zeka birimi in the X-instruction execute stage. Producers push one or two words per cycle; the consumer pops one word per cycle from a first-word-fall-through head. Over the fixed 16×32 dual-write buffer it adds explicit full/empty/occupancy status, a backpressure ready signal, flush, and overflow/underflow protection.

## Interface
Parameters:
- `VERI_W`, 32, data word width in bits.
- `DERINLIK`, 16, number of entries; power of two, ≥ 4.

Ports (`AW = $clog2(DERINLIK)`):
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `temizle_i` in 1: synchronous flush.
- `yaz1_en_i` in 1: push `yaz1_deger_i`.
- `yaz1_deger_i` in `VERI_W`: first push word.
- `yaz2_en_i` in 1: push `yaz2_deger_i` after word 1; honoured only with `yaz1_en_i`.
- `yaz2_deger_i` in `VERI_W`: second push word.
- `yaz_hazir_o` out 1: at least 2 free entries.
- `oku_en_i` in 1: pop the head word.
- `oku_deger_o` out `VERI_W`: head word; valid when `oku_gecerli_o`=1.
- `oku_gecerli_o` out 1: FIFO non-empty.
- `doluluk_o` out `AW+1`: occupancy, 0..`DERINLIK`.
- `dolu_o` out 1: occupancy = `DERINLIK`.
- `tasma_o` out 1: sticky overflow flag.
- `alt_tasma_o` out 1: sticky underflow flag.

## Operation
- Storage: `DERINLIK` × `VERI_W` array; write pointer `yp`, read pointer `op` (`AW` bits, natural wrap); occupancy register `sayi` (`AW+1` bits).
- Requested push count `n = yaz1_en_i + (yaz1_en_i & yaz2_en_i)`; `yaz2_en_i` alone is ignored and is not an error.
- Effective pop `p = oku_en_i & (sayi != 0)`. Pop on empty is ignored, sets `alt_tasma_o`, and leaves state unchanged.
- Free space for this cycle = `DERINLIK - sayi + p`. A simultaneous pop frees space for the same-cycle push.
- Push accepted only if `n` ≤ free space. Push is all-or-nothing: if two words do not fit, neither is written and `tasma_o` is set.
- Accepted push: word 1 goes to `mem[yp]`, word 2 to `mem[yp+1]` (mod `DERINLIK`); `yp += n`.
- Pop: `op += 1`.
- Update: `sayi <= sayi + n_acc - p`.
- Push into an empty FIFO together with `oku_en_i`: no bypass. The pop is an underflow (ignored, flagged) and the push is accepted.
- `oku_deger_o = mem[op]`, combinational from the array. Value is don't-care when empty.
- `bos`/`dolu` are decoded from `sayi`. `yaz_hazir_o = (DERINLIK - sayi) >= 2`.
- Priority: `rst_ni` = 0 first, then `temizle_i` = 1, then normal push/pop.
- Flush: `yp`, `op`, `sayi`, `tasma_o`, `alt_tasma_o` all go to 0. Same-cycle push and pop are discarded. Array contents are retained but unreachable.
- Reset mid-operation (`rst_ni` = 0 for one edge): same effect as flush, and the array is not cleared.

## Timing
- Reset values: `oku_gecerli_o`=0, `doluluk_o`=0, `dolu_o`=0, `yaz_hazir_o`=1, `tasma_o`=0, `alt_tasma_o`=0. `oku_deger_o` is undefined.
- Push at edge N: word visible on `oku_deger_o` and counted in `doluluk_o` after edge N, i.e. 1-cycle write-to-read latency.
- Pop at edge N: next word on `oku_deger_o` after edge N; zero-latency head (FWFT).
- Sustained throughput: 2 pushes and 1 pop per cycle until full.
- Sticky flags set on the edge of the offending request and hold until reset or flush.
- `yaz_hazir_o` is advisory. Producers that ignore it rely on the all-or-nothing drop.

## Configuration
- `YZ_KUYRUK_HATA_BAYRAK_EN` defined: `tasma_o` and `alt_tasma_o` behave as specified above.
- Not defined: both outputs tied to 0 and their registers are not built. Drop and ignore behaviour is unchanged.

## Test plan
- Reset, then push (1,2 words) A=0x11, B=0x22 in one cycle → next cycle `doluluk_o`=2, `oku_deger_o`=0x11; pop → `oku_deger_o`=0x22, `doluluk_o`=1.
- Fill `DERINLIK`=16 with 8 dual pushes of values 0..15 → `dolu_o`=1, `yaz_hazir_o`=0. One more single push (0xFF) → dropped, `tasma_o`=1. Pop 16 times → values 0..15 in order, then `oku_gecerli_o`=0.
- Occupancy 15, dual push plus pop in the same cycle → accepted (free=2), `doluluk_o`=16. Occupancy 15, dual push without pop → both words dropped, `doluluk_o`=15, `tasma_o`=1.
- Pop on empty → `alt_tasma_o`=1, `doluluk_o`=0. Push 0x33 plus pop on empty → `doluluk_o`=1, head=0x33, `alt_tasma_o`=1.
- Run 40 cycles of dual push / single pop with pointer wrap; scoreboard pop order matches push order. Then `temizle_i` with push active → `doluluk_o`=0, flags 0, push discarded.
- `yaz2_en_i`=1 with `yaz1_en_i`=0 → no write, no flag. Macro undefined build → flags stay 0 under the overflow and underflow stimuli above.
